dram_line_fill: RTL
===================

DRAM_LINE_FILL -- requirements
Module: dram_line_fill

Interface
REQ-001 Parameter ACCESS_LAT, default 4: idle cycles between accepting a request and the first memory read; legal range 1..15.
REQ-002 Parameter LINE_WORDS, default 8: 32-bit words per cache line; fixed at 8 in this revision.
REQ-003 clock  in  1  single clock for all state; every flop is rising-edge triggered.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 dram_request  in  1  line-fill request from the instruction cache; held high until the line is consumed.
REQ-006 dram_request_addr  in  32  word address of the requested line; bits [2:0] are ignored.
REQ-007 dram_data  out  32  returned instruction word.
REQ-008 dram_valid  out  1  one-cycle strobe qualifying dram_data; one strobe per word.
REQ-009 mem_rd  out  1  read strobe to the backing word memory.
REQ-010 mem_addr  out  32  word address for mem_rd.
REQ-011 mem_rdata  in  32  memory read data, valid exactly one cycle after mem_rd.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 fill_count  out  16  number of completed line fills; wraps from 0xFFFF to 0.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, WAIT, BURST, DONE.
REQ-015 IDLE to WAIT: dram_request=1 at a clock edge; base SHALL latch {dram_request_addr[31:3],3'b000}; the latency counter SHALL load ACCESS_LAT-1.
REQ-016 WAIT: the counter SHALL decrement each cycle; at 0 the FSM SHALL go to BURST with beat index 0.
REQ-017 BURST: mem_rd=1 every cycle, mem_addr=base+beat; beat SHALL increment 0..7 in ascending order; after beat 7 the FSM SHALL go to DONE.
REQ-018 dram_valid SHALL be mem_rd delayed one cycle; dram_data SHALL be mem_rdata, registered through no extra stage.
REQ-019 Latency: request first sampled at edge T gives first mem_rd in cycle T+ACCESS_LAT+1, first dram_valid in T+ACCESS_LAT+2, eighth dram_valid in T+ACCESS_LAT+9.
REQ-020 DONE: the FSM SHALL stay in DONE while dram_request=1 and return to IDLE on the first cycle it is 0; it SHALL NOT start a new fill from DONE.
REQ-021 fill_count SHALL increment by 1 on the cycle the eighth dram_valid is driven.
REQ-022 Abort: if dram_request=0 in WAIT or BURST, the FSM SHALL go to IDLE next edge and issue no further mem_rd.
REQ-023 Abort: a dram_valid for a mem_rd already issued SHALL still be driven, and fill_count SHALL NOT increment.
REQ-024 dram_request_addr changes after acceptance SHALL be ignored until the next IDLE acceptance.
REQ-025 In IDLE, WAIT and DONE, mem_rd=0 and dram_valid=0; mem_addr SHALL hold its last value.

Reset
REQ-026 rst=1 SHALL force, asynchronously, state=IDLE, dram_valid=0, dram_data=0, mem_rd=0, mem_addr=0, busy=0, fill_count=0, counters=0 and base=0.
REQ-027 rst asserted mid-burst SHALL drop dram_valid and mem_rd immediately; no partial-line strobes SHALL follow deassertion.
REQ-028 The first fill SHALL be accepted no earlier than the first edge after rst deasserts.

Structure
REQ-029 Shared package dram_fill_pkg SHALL hold the state enumeration, LINE_WORDS=8, and the widths of the beat and latency counters.
REQ-030 The block SHALL be a single module with no sub-module; the beat and latency counters are inline.

Verification
REQ-031 ACCESS_LAT=4, request at T with addr 0x0000_0105: mem_addr 0x100..0x107 in cycles T+5..T+12; dram_valid T+6..T+13; fill_count=1.
REQ-032 Memory word = address: dram_data sequence 0x100..0x107; an I_Cache-style 8-entry shift register holds word 0 at entry 0.
REQ-033 Request held 2 cycles after the eighth beat, then dropped: the FSM stays in DONE, returns to IDLE, and a new request one cycle later starts a second fill with fill_count=2.
REQ-034 Request dropped after 3 mem_rd: at most 4 dram_valid pulses, then IDLE; fill_count unchanged; no further mem_rd.
REQ-035 rst pulsed during beat 5: all outputs 0 within the same cycle; the next request completes a full 8-word fill.
REQ-036 fill_count preset by force to 0xFFFF, one fill completes: fill_count=0x0000.

Source files
------------

// File: rtl/dram_fill_pkg.sv
// Shared types and sizes for the DRAM line-fill engine.
package dram_fill_pkg;

  localparam int LINE_WORDS = 8;   // 32-bit words per cache line
  localparam int BEAT_W     = 3;   // beat index width, covers 0..LINE_WORDS-1
  localparam int LAT_W      = 4;   // latency counter width, covers ACCESS_LAT 1..15

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } state_t;

endpackage

// File: rtl/dram_line_fill_if.sv
// Cache-side request/return and memory-side read signals of the line-fill engine.
interface dram_line_fill_if;

  logic        dram_request;
  logic [31:0] dram_request_addr;
  logic [31:0] dram_data;
  logic        dram_valid;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  // Fill engine side
  modport slave (
    input  dram_request, dram_request_addr, mem_rdata,
    output dram_data, dram_valid, mem_rd, mem_addr
  );

  // Cache + memory side
  modport master (
    output dram_request, dram_request_addr, mem_rdata,
    input  dram_data, dram_valid, mem_rd, mem_addr
  );

endinterface

// File: rtl/dram_line_fill.sv
// Line-fill engine: accepts an I-cache miss, waits ACCESS_LAT cycles, then
// streams LINE_WORDS sequential word reads and returns each word as a strobe.
module dram_line_fill
  import dram_fill_pkg::*;
#(
  parameter int ACCESS_LAT = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic            clock,
  input  logic            rst,
  dram_line_fill_if.slave bus,
  output logic            busy,
  output logic [15:0]     fill_count
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_t            state;
  logic [31:0]       base;
  logic [BEAT_W-1:0] beat;
  logic [LAT_W-1:0]  lat_cnt;

  assign busy = (state != IDLE);

  // Memory returns data one cycle after mem_rd, which is exactly when the
  // delayed strobe is high, so the data is passed through without a register.
  // Gating by the strobe keeps the bus at zero while idle and in reset.
  assign bus.dram_data = bus.dram_valid ? bus.mem_rdata : 32'd0;

  // FSM with registered memory strobe/address, return strobe and fill counter.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      base           <= 32'd0;
      beat           <= '0;
      lat_cnt        <= '0;
      bus.mem_rd     <= 1'b0;
      bus.mem_addr   <= 32'd0;
      bus.dram_valid <= 1'b0;
      fill_count     <= 16'd0;
    end else begin
      // Every issued read gets its return strobe, even if the fill is aborted.
      bus.dram_valid <= bus.mem_rd;
      case (state)
        IDLE: begin
          bus.mem_rd <= 1'b0;
          if (bus.dram_request) begin
            state   <= WAIT;
            base    <= bus.dram_request_addr & ~32'h7;
            lat_cnt <= LAT_W'(ACCESS_LAT - 1);
          end
        end
        WAIT: begin
          if (!bus.dram_request) begin
            state <= IDLE;
          end else if (lat_cnt == '0) begin
            state        <= BURST;
            beat         <= '0;
            bus.mem_rd   <= 1'b1;
            bus.mem_addr <= base;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        BURST: begin
          if (!bus.dram_request) begin
            state      <= IDLE;
            bus.mem_rd <= 1'b0;
          end else if (beat == LAST_BEAT) begin
            // The last read's strobe is driven on this edge: line complete.
            state      <= DONE;
            bus.mem_rd <= 1'b0;
            fill_count <= fill_count + 16'd1;
          end else begin
            beat         <= beat + BEAT_W'(1);
            bus.mem_rd   <= 1'b1;
            bus.mem_addr <= base + 32'(beat) + 32'd1;
          end
        end
        DONE: begin
          // Wait for the cache to drop the request; never chain a new fill.
          if (!bus.dram_request) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
